// File: rtl/conv_sched_pkg.sv
// conv_sched_pkg: shared types and width helpers for the conv layer scheduler.
package conv_sched_pkg;

    // Scheduler states. The encoding is visible on the top-level debug port.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_HOLD  = 3'd3,
        S_NEXT  = 3'd4,
        S_DRAIN = 3'd5
    } sched_state_e;

    // Width of one output feature map (valid convolution, stride 1).
    function automatic int map_width(input int h, input int w, input int s, input int dw);
        return (h - s + 1) * (w - s + 1) * dw;
    endfunction

    // Width of one filter (depth x size x size elements).
    function automatic int filt_width(input int d, input int s, input int dw);
        return d * s * s * dw;
    endfunction

    // Width of a filter index; a single-filter bank still gets one bit.
    function automatic int idx_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

    // Width of the latency counter, which has to hold the value lat itself.
    function automatic int cnt_width(input int lat);
        return $clog2(lat + 1);
    endfunction

endpackage

// File: rtl/conv_sched_outbuf.sv
// conv_sched_outbuf: one-entry output buffer between the scheduler and the
// map consumer, supporting a capture and a drain in the same cycle plus a flush.
module conv_sched_outbuf #(
    parameter int DW = 16,
    parameter int IW = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cap_i,
    input  logic [DW-1:0] cap_data_i,
    input  logic [IW-1:0] cap_idx_i,
    input  logic          flush_i,
    input  logic          ready_i,
    output logic          valid_o,
    output logic [DW-1:0] data_o,
    output logic [IW-1:0] idx_o
);

    // Handshake: a map moves to the consumer on every edge where valid_o and
    // ready_i are both 1. valid_o never depends on ready_i combinationally, and
    // data_o/idx_o do not change while valid_o=1 unless that edge is a transfer
    // or a new capture. A capture on a transfer edge replaces the outgoing map,
    // so valid_o stays 1. Flush empties the buffer and beats a capture.
    logic          valid_q;
    logic [DW-1:0] data_q;
    logic [IW-1:0] idx_q;

    // Occupancy flag: flush clears, capture fills, a transfer empties.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else if (flush_i) begin
            valid_q <= 1'b0;
        end else if (cap_i) begin
            valid_q <= 1'b1;
        end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
        end
    end

    // Payload registers load only on capture so they hold under back-pressure.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            idx_q  <= '0;
        end else if (cap_i && !flush_i) begin
            data_q <= cap_data_i;
            idx_q  <= cap_idx_i;
        end
    end

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign idx_o   = idx_q;

endmodule

// File: rtl/conv_layer_sched.sv
// conv_layer_sched: time-shares one single-filter convolution engine across a
// bank of K filters and hands each feature map out through a one-entry buffer.
// Optional macro CONV_SCHED_PERF_EN adds the perf_busy / perf_stall counters.
module conv_layer_sched
    import conv_sched_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int D          = 1,
    parameter int S          = 5,
    parameter int H          = 32,
    parameter int W          = 32,
    parameter int K          = 6,
    parameter int CONV_LAT   = 1568
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          start,
    input  logic                                          abort,
    input  logic [K*filt_width(D, S, DATA_WIDTH)-1:0]     fit_bank,
    output logic                                          busy,
    output logic                                          done,
    output logic                                          eng_rst,
    output logic [filt_width(D, S, DATA_WIDTH)-1:0]       eng_fit,
    input  logic [map_width(H, W, S, DATA_WIDTH)-1:0]     eng_res,
    output logic                                          res_valid,
    input  logic                                          res_ready,
    output logic [map_width(H, W, S, DATA_WIDTH)-1:0]     res_data,
    output logic [idx_width(K)-1:0]                       res_idx,
    output logic [2:0]                                    dbg_state
`ifdef CONV_SCHED_PERF_EN
    ,
    output logic [31:0]                                   perf_busy,
    output logic [31:0]                                   perf_stall
`endif
);

    localparam int FILT_W = filt_width(D, S, DATA_WIDTH);
    localparam int MAP_W  = map_width(H, W, S, DATA_WIDTH);
    localparam int IDX_W  = idx_width(K);
    localparam int CNT_W  = cnt_width(CONV_LAT);

    localparam logic [IDX_W-1:0] LAST_F   = IDX_W'(K - 1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(CONV_LAT);

    sched_state_e          state_q, state_d;
    logic [K*FILT_W-1:0]   bank_q;
    logic [IDX_W-1:0]      f_q, f_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  start_acc;
    logic                  cap;
    logic                  flush;
    logic                  buf_free;

    // The buffer can take a new map if it is empty or being drained this cycle.
    assign buf_free = !res_valid || res_ready;

    // Next-state and control decode; abort overrides everything at the end.
    // RUN lasts CONV_LAT+1 cycles: the engine leaves reset at the end of the
    // first RUN cycle, clocks CONV_LAT times, and its result is stable during
    // the cycle in which the counter equals CONV_LAT.
    always_comb begin
        state_d   = state_q;
        f_d       = f_q;
        cnt_d     = cnt_q;
        start_acc = 1'b0;
        cap       = 1'b0;
        flush     = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    f_d       = '0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_RUN;
            end
            S_RUN: begin
                if (cnt_q == CNT_DONE) begin
                    if (buf_free) begin
                        cap     = 1'b1;
                        state_d = S_NEXT;
                    end else begin
                        state_d = S_HOLD;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_HOLD: begin
                if (buf_free) begin
                    cap     = 1'b1;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (f_q == LAST_F) begin
                    state_d = S_DRAIN;
                end else begin
                    f_d     = f_q + IDX_W'(1);
                    state_d = S_LOAD;
                end
            end
            S_DRAIN: begin
                if (buf_free) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d   = S_IDLE;
            start_acc = 1'b0;
            cap       = 1'b0;
            done      = 1'b0;
            flush     = 1'b1;
        end
    end

    // State, filter index and latency counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            f_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            f_q     <= f_d;
            cnt_q   <= cnt_d;
        end
    end

    // Filter bank snapshot, taken only on an accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_q <= '0;
        end else if (start_acc) begin
            bank_q <= fit_bank;
        end
    end

    // Engine only runs in RUN/HOLD; HOLD keeps it running so its result stays put.
    assign eng_rst   = !((state_q == S_RUN) || (state_q == S_HOLD));
    assign eng_fit   = bank_q[int'(f_q)*FILT_W +: FILT_W];
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

    conv_sched_outbuf #(
        .DW (MAP_W),
        .IW (IDX_W)
    ) u_outbuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .cap_i      (cap),
        .cap_data_i (eng_res),
        .cap_idx_i  (f_q),
        .flush_i    (flush),
        .ready_i    (res_ready),
        .valid_o    (res_valid),
        .data_o     (res_data),
        .idx_o      (res_idx)
    );

`ifdef CONV_SCHED_PERF_EN
    logic [31:0] perf_busy_q;
    logic [31:0] perf_stall_q;
    logic        stall_cyc;

    assign stall_cyc = ((state_q == S_HOLD) || (state_q == S_DRAIN)) && res_valid && !res_ready;

    // Saturating activity counters, restarted by each accepted start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else if (start_acc) begin
            perf_busy_q  <= '0;
            perf_stall_q <= '0;
        end else begin
            if (busy && (perf_busy_q != 32'hFFFF_FFFF)) begin
                perf_busy_q <= perf_busy_q + 32'd1;
            end
            if (stall_cyc && (perf_stall_q != 32'hFFFF_FFFF)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_busy  = perf_busy_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule

// File: tb/tb_conv_layer_sched.sv
// tb_conv_layer_sched: self-checking bench for conv_layer_sched with a small
// behavioural engine model (K=2, CONV_LAT=4, tiny 3x3 image, 2x2 filter).
module tb_conv_layer_sched;

    localparam int DATA_WIDTH = 4;
    localparam int D          = 1;
    localparam int S          = 2;
    localparam int H          = 3;
    localparam int W          = 3;
    localparam int K          = 2;
    localparam int CONV_LAT   = 4;
    localparam int FILT_W     = D * S * S * DATA_WIDTH;
    localparam int MAP_W      = (H - S + 1) * (W - S + 1) * DATA_WIDTH;
    localparam int IDX_W      = 1;
    localparam int BANK_W     = K * FILT_W;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_LOAD = 3'd1;
    localparam logic [2:0] ST_RUN  = 3'd2;
    localparam logic [2:0] ST_HOLD = 3'd3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic [BANK_W-1:0] fit_bank = '0;
    logic              busy, done, eng_rst;
    logic [FILT_W-1:0] eng_fit;
    logic [MAP_W-1:0]  eng_res;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic [MAP_W-1:0]  res_data;
    logic [IDX_W-1:0]  res_idx;
    logic [2:0]        dbg_state;
`ifdef CONV_SCHED_PERF_EN
    logic [31:0]       perf_busy, perf_stall;
`endif

    conv_layer_sched #(
        .DATA_WIDTH (DATA_WIDTH), .D (D), .S (S), .H (H), .W (W), .K (K), .CONV_LAT (CONV_LAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .abort     (abort),
        .fit_bank  (fit_bank),
        .busy      (busy),
        .done      (done),
        .eng_rst   (eng_rst),
        .eng_fit   (eng_fit),
        .eng_res   (eng_res),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_data  (res_data),
        .res_idx   (res_idx),
        .dbg_state (dbg_state)
`ifdef CONV_SCHED_PERF_EN
        ,
        .perf_busy  (perf_busy),
        .perf_stall (perf_stall)
`endif
    );

    // ---------------- engine model ----------------
    function automatic logic [MAP_W-1:0] map_of(input logic [FILT_W-1:0] f);
        return {f[7:0], f[15:8]} ^ 16'h5A3C;
    endfunction

    int eng_cnt = 0;
    always @(posedge clk) begin
        if (eng_rst) eng_cnt <= 0;
        else if (eng_cnt < CONV_LAT) eng_cnt <= eng_cnt + 1;
    end
    // Before CONV_LAT clocks out of reset the engine shows a wrong value.
    assign eng_res = (eng_cnt == CONV_LAT) ? map_of(eng_fit) : ~map_of(eng_fit);

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    logic [MAP_W+IDX_W-1:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_bank(input logic [BANK_W-1:0] bank);
        for (int k = 0; k < K; k++) begin
            exp_q.push_back({IDX_W'(k), map_of(bank[k*FILT_W +: FILT_W])});
        end
    endtask

    // Called at each negedge: a transfer happens on the next posedge.
    task automatic sb_sample();
        logic [MAP_W+IDX_W-1:0] exp_v;
        if (rst_n && !abort && res_valid && res_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got idx %0d data %0h expected no map", res_idx, res_data);
            end else begin
                exp_v = exp_q.pop_front();
                check("sb_map", {res_idx, res_data}, exp_v);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_eng_rst"}, eng_rst, 1'b1);
        check({tag, "_eng_fit"}, eng_fit, '0);
        check({tag, "_res_valid"}, res_valid, 1'b0);
        check({tag, "_res_data"}, res_data, '0);
        check({tag, "_res_idx"}, res_idx, '0);
        check({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    // ---------------- driver: one full layer run ----------------
    // Edge numbering: the edge that accepts start is edge 0; a value "at edge e"
    // is the one seen between edge e and edge e+1.
    task automatic run_case(input int row, input logic [BANK_W-1:0] bank, input int ready_until,
                            input bit poke, input int exp_cap1, input int exp_done,
                            input int exp_fall, input int exp_hold);
        int first_v, cap1, done_e, done_n, fall_e, hold_n, load_n, viol;
        logic pv, pr;
        logic [MAP_W-1:0] pd;
        logic [IDX_W-1:0] pi;
        first_v = -1; cap1 = -1; done_e = -1; done_n = 0; fall_e = -1;
        hold_n = 0; load_n = 0; viol = 0; pv = 1'b0; pr = 1'b0; pd = '0; pi = '0;
        fit_bank  = bank;
        start     = 1'b1;
        res_ready = (ready_until <= 0);
        push_bank(bank);
        step();
        start = 1'b0;
        for (int e = 0; e < 60 && fall_e < 0; e++) begin
            res_ready = (e + 1 >= ready_until);
            if (poke && e == 2) begin
                start    = 1'b1;
                fit_bank = ~bank;
            end
            if (poke && e == 3) start = 1'b0;
            @(negedge clk);
            sb_sample();
            if (res_valid && first_v < 0) first_v = e;
            if (res_valid && res_idx == 1'b1 && cap1 < 0) cap1 = e;
            if (done) begin
                done_n++;
                done_e = e;
            end
            if (!busy && fall_e < 0) fall_e = e;
            if (dbg_state == ST_HOLD) hold_n++;
            if ((dbg_state == ST_IDLE || dbg_state == ST_LOAD) && !eng_rst) viol++;
            if ((dbg_state == ST_RUN || dbg_state == ST_HOLD) && eng_rst) viol++;
            if (pv && !pr && !(res_valid && res_data == pd && res_idx == pi)) viol++;
            if (dbg_state == ST_LOAD) begin
                if (load_n < K) check($sformatf("row%0d_load_fit%0d", row, load_n), eng_fit,
                                      bank[load_n*FILT_W +: FILT_W]);
                else viol++;
                load_n++;
            end
            pv = res_valid; pr = res_ready; pd = res_data; pi = res_idx;
            step();
        end
        check($sformatf("row%0d_first_valid_edge", row), first_v, 6);
        check($sformatf("row%0d_map1_edge", row), cap1, exp_cap1);
        check($sformatf("row%0d_done_edge", row), done_e, exp_done);
        check($sformatf("row%0d_done_count", row), done_n, 1);
        check($sformatf("row%0d_busy_fall_edge", row), fall_e, exp_fall);
        check($sformatf("row%0d_hold_cycles", row), hold_n, exp_hold);
        check($sformatf("row%0d_load_count", row), load_n, K);
        check($sformatf("row%0d_protocol_violations", row), viol, 0);
        step();
        check($sformatf("row%0d_sb_empty", row), exp_q.size(), 0);
        exp_q.delete();
    endtask

    typedef struct {
        logic [BANK_W-1:0] bank;
        int                ready_until;
        bit                poke;
        int                exp_cap1;
        int                exp_done;
        int                exp_fall;
        int                exp_hold;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int n;
        // ---------------- reset state ----------------
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_vals("por");
        rst_n = 1'b1;
        step();

        // ---------------- table-driven runs ----------------
        vecs[0] = '{32'h1234_ABCD, 0,  1'b0, 13, 14, 15, 0};
        vecs[1] = '{32'h0F0F_7E81, 8,  1'b0, 13, 14, 15, 0};
        vecs[2] = '{32'hC3A5_0001, 16, 1'b0, 16, 17, 18, 3};
        vecs[3] = '{32'h55AA_FFFF, 20, 1'b0, 20, 21, 22, 7};
        vecs[4] = '{32'h8001_6BD2, 0,  1'b1, 13, 14, 15, 0};
        vecs[5] = '{32'(($urandom << 8) ^ $urandom), int'($urandom_range(0, 13)), 1'b0, 13, 14, 15, 0};
        for (int i = 0; i < 6; i++) begin
            run_case(i, vecs[i].bank, vecs[i].ready_until, vecs[i].poke,
                     vecs[i].exp_cap1, vecs[i].exp_done, vecs[i].exp_fall, vecs[i].exp_hold);
            repeat (2) step();
        end

        // ---------------- abort in third RUN cycle of filter 1 ----------------
        fit_bank = 32'hBEEF_1357;
        start = 1'b1;
        res_ready = 1'b1;
        push_bank(fit_bank);
        step();
        start = 1'b0;
        for (int e = 0; e < 10; e++) begin
            @(negedge clk);
            sb_sample();
            step();
        end
        abort = 1'b1;
        @(negedge clk);
        check("abort_pre_state", dbg_state, ST_RUN);
        step();
        abort = 1'b0;
        @(negedge clk);
        check("abort_res_valid", res_valid, 1'b0);
        check("abort_busy", busy, 1'b0);
        check("abort_eng_rst", eng_rst, 1'b1);
        check("abort_pending_maps", exp_q.size(), 1);
        exp_q.delete();
        n = 0;
        for (int e = 0; e < 20; e++) begin
            step();
            @(negedge clk);
            if (done || res_valid || busy) n++;
        end
        check("abort_quiet_after", n, 0);
        step();

        // ---------------- abort while buffer full flushes it ----------------
        fit_bank = 32'h2468_ACE0;
        start = 1'b1;
        res_ready = 1'b0;
        step();
        start = 1'b0;
        repeat (8) step();
        @(negedge clk);
        check("flush_pre_valid", res_valid, 1'b1);
        step();
        abort = 1'b1;
        step();
        abort = 1'b0;
        @(negedge clk);
        check("flush_res_valid", res_valid, 1'b0);
        check("flush_state", dbg_state, ST_IDLE);
        step();

        // ---------------- abort beats start in IDLE ----------------
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("abort_vs_start_busy", busy, 1'b0);
        step();

        // ---------------- async reset while a map is held ----------------
        fit_bank = 32'h7777_1111;
        start = 1'b1;
        res_ready = 1'b0;
        step();
        start = 1'b0;
        repeat (7) step();
        check("rst_pre_valid", res_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_vals("async_rst");
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        exp_q.delete();
        step();
        run_case(10, 32'h9ABC_4321, 0, 1'b0, 13, 14, 15, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule
